rmt_recovery_sequencer: RTL and testbench

- Sequences the two register map tables (retirement RMT, rename RMT) outside normal rename/commit flow.
- INIT: sweeps every logical register and writes the identity-offset mapping into both tables.
- RECOVER: after a pipeline flush, copies the retirement RMT into the rename RMT, READ_NUM entries per cycle.
- Sits beside the rename stage; stalls rename and commit while it owns the tables.

---
 rtl/rmt_recovery_sequencer_pkg.sv | 20 ++
 rtl/rmt_sweep_counter.sv | 39 +++
 rtl/rmt_recovery_sequencer.sv | 149 ++++++++++++++
 tb/tb_rmt_recovery_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_recovery_sequencer_pkg.sv
// Shared types and default sizing for the RMT init/recovery sequencer.
package rmt_recovery_sequencer_pkg;

    localparam int unsigned RMT_ENTRY_NUM              = 64;
    localparam int unsigned SCALAR_FREE_LIST_ENTRY_NUM = 64;
    localparam int unsigned RENAME_WIDTH               = 2;

    localparam int unsigned LREG_NUM_PATH_W = 6;
    localparam int unsigned PREG_NUM_PATH_W = 7;

    typedef logic [LREG_NUM_PATH_W-1:0] lreg_num_path_t;
    typedef logic [PREG_NUM_PATH_W-1:0] preg_num_path_t;

    typedef enum logic [1:0] {
        SeqIdle,
        SeqInit,
        SeqRecover
    } rmt_seq_state_e;

endpackage

// File: rtl/rmt_sweep_counter.sv
// Sweep index for the RMT sequencer: clear, step by 1 or READ_NUM, and flag the last group.
module rmt_sweep_counter #(
    parameter int unsigned LREG_NUM = 64,
    parameter int unsigned READ_NUM = 2,
    parameter int unsigned CNT_W    = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             step_en_i,
    input  logic             wide_step_i,
    output logic [CNT_W-1:0] idx_o,
    output logic             last_o
);

    logic [CNT_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (step_en_i) begin
            idx_d = idx_q + (wide_step_i ? CNT_W'(READ_NUM) : CNT_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = wide_step_i ? (idx_q == CNT_W'(LREG_NUM - READ_NUM))
                                : (idx_q == CNT_W'(LREG_NUM - 1));

endmodule

// File: rtl/rmt_recovery_sequencer.sv
// Owns both RMTs during init sweep and post-flush recovery copy; stalls rename/commit meanwhile.
// Optional macro RMT_AUTO_INIT_EN: enter INIT on the first clock edge after reset release.
module rmt_recovery_sequencer
    import rmt_recovery_sequencer_pkg::*;
#(
    parameter int unsigned LREG_NUM  = RMT_ENTRY_NUM,
    parameter int unsigned PREG_BASE = SCALAR_FREE_LIST_ENTRY_NUM,
    parameter int unsigned READ_NUM  = RENAME_WIDTH,
    parameter int unsigned LREG_W    = LREG_NUM_PATH_W,
    parameter int unsigned PREG_W    = PREG_NUM_PATH_W
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         init_start_i,
    input  logic                         recover_req_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         rename_stall_o,
    output logic                         commit_stall_o,
    output logic                         ret_wr_en_o,
    output logic [LREG_W-1:0]            ret_wr_addr_o,
    output logic [PREG_W-1:0]            ret_wr_data_o,
    output logic [READ_NUM*LREG_W-1:0]   ret_rd_addr_o,
    input  logic [READ_NUM*PREG_W-1:0]   ret_rd_data_i,
    output logic [READ_NUM-1:0]          ren_wr_en_o,
    output logic [READ_NUM*LREG_W-1:0]   ren_wr_addr_o,
    output logic [READ_NUM*PREG_W-1:0]   ren_wr_data_o
);

    localparam int unsigned CNT_W = LREG_W + 1;

    rmt_seq_state_e   state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] idx;
    logic             idx_last;
    logic             cnt_clear;
    logic             start_init;
    logic [31:0]      init_data;

`ifdef RMT_AUTO_INIT_EN
    logic auto_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= 1'b0;
        end
    end

    assign start_init = init_start_i | auto_q;
`else
    assign start_init = init_start_i;
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            SeqIdle: begin
                if (start_init) begin
                    state_d = SeqInit;
                end else if (recover_req_i) begin
                    state_d = SeqRecover;
                end
            end
            SeqInit: begin
                if (idx_last) begin
                    state_d = SeqIdle;
                    done_d  = 1'b1;
                end
            end
            SeqRecover: begin
                // An init request aborts recovery without signalling completion.
                if (init_start_i) begin
                    state_d = SeqInit;
                end else if (idx_last) begin
                    state_d = SeqIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = SeqIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SeqIdle;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Index restarts at 0 on every state change so each sweep begins at entry 0.
    assign cnt_clear = (state_q == SeqIdle) || (state_d != state_q);

    rmt_sweep_counter #(
        .LREG_NUM (LREG_NUM),
        .READ_NUM (READ_NUM),
        .CNT_W    (CNT_W)
    ) u_sweep_counter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (cnt_clear),
        .step_en_i   (!cnt_clear),
        .wide_step_i (state_q == SeqRecover),
        .idx_o       (idx),
        .last_o      (idx_last)
    );

    assign init_data = 32'(idx) + 32'(PREG_BASE);

    always_comb begin
        ret_wr_en_o   = 1'b0;
        ret_wr_addr_o = '0;
        ret_wr_data_o = '0;
        ret_rd_addr_o = '0;
        ren_wr_en_o   = '0;
        ren_wr_addr_o = '0;
        ren_wr_data_o = '0;
        unique case (state_q)
            SeqInit: begin
                ret_wr_en_o                = 1'b1;
                ret_wr_addr_o              = idx[LREG_W-1:0];
                ret_wr_data_o              = init_data[PREG_W-1:0];
                ren_wr_en_o[0]             = 1'b1;
                ren_wr_addr_o[LREG_W-1:0]  = idx[LREG_W-1:0];
                ren_wr_data_o[PREG_W-1:0]  = init_data[PREG_W-1:0];
            end
            SeqRecover: begin
                ren_wr_en_o = '1;
                for (int k = 0; k < int'(READ_NUM); k++) begin
                    ret_rd_addr_o[k*LREG_W +: LREG_W] = LREG_W'(idx + CNT_W'(k));
                    ren_wr_addr_o[k*LREG_W +: LREG_W] = LREG_W'(idx + CNT_W'(k));
                    ren_wr_data_o[k*PREG_W +: PREG_W] = ret_rd_data_i[k*PREG_W +: PREG_W];
                end
            end
            default: ;
        endcase
    end

    assign busy_o         = (state_q != SeqIdle);
    assign rename_stall_o = busy_o;
    assign commit_stall_o = busy_o;
    assign done_o         = done_q;

endmodule

// File: tb/tb_rmt_recovery_sequencer.sv
// Directed self-checking bench for rmt_recovery_sequencer (default parameters).
module tb_rmt_recovery_sequencer;

    localparam int LW = 6;
    localparam int PW = 7;
    localparam int RN = 2;

    logic            clk;
    logic            rst_n;
    logic            init_start;
    logic            recover_req;
    logic            busy;
    logic            done;
    logic            rename_stall;
    logic            commit_stall;
    logic            ret_wr_en;
    logic [LW-1:0]   ret_wr_addr;
    logic [PW-1:0]   ret_wr_data;
    logic [RN*LW-1:0] ret_rd_addr;
    logic [RN*PW-1:0] ret_rd_data;
    logic [RN-1:0]   ren_wr_en;
    logic [RN*LW-1:0] ren_wr_addr;
    logic [RN*PW-1:0] ren_wr_data;

    logic [PW-1:0] rmap [64];

    int n_checks = 0;
    int n_errors = 0;

    rmt_recovery_sequencer u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .init_start_i   (init_start),
        .recover_req_i  (recover_req),
        .busy_o         (busy),
        .done_o         (done),
        .rename_stall_o (rename_stall),
        .commit_stall_o (commit_stall),
        .ret_wr_en_o    (ret_wr_en),
        .ret_wr_addr_o  (ret_wr_addr),
        .ret_wr_data_o  (ret_wr_data),
        .ret_rd_addr_o  (ret_rd_addr),
        .ret_rd_data_i  (ret_rd_data),
        .ren_wr_en_o    (ren_wr_en),
        .ren_wr_addr_o  (ren_wr_addr),
        .ren_wr_data_o  (ren_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read retirement RMT model.
    always_comb begin
        ret_rd_data = '0;
        for (int k = 0; k < RN; k++) begin
            ret_rd_data[k*PW +: PW] = rmap[ret_rd_addr[k*LW +: LW]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_init(input int i);
        logic [LW-1:0] a;
        logic [PW-1:0] d;
        a = LW'(i);
        d = PW'(i + 64);
        check("init_busy", 32'(busy), 32'd1);
        check("init_stalls", {30'd0, rename_stall, commit_stall}, 32'd3);
        check("init_ret_wr_en", 32'(ret_wr_en), 32'd1);
        check("init_ret_wr_addr", 32'(ret_wr_addr), 32'(a));
        check("init_ret_wr_data", 32'(ret_wr_data), 32'(d));
        check("init_ren_wr_en", 32'(ren_wr_en), 32'd1);
        check("init_ren_wr_addr", 32'(ren_wr_addr), {20'd0, 6'd0, a});
        check("init_ren_wr_data", 32'(ren_wr_data), {18'd0, 7'd0, d});
        check("init_done", 32'(done), 32'd0);
    endtask

    task automatic chk_recover(input int j);
        logic [RN*LW-1:0] a;
        logic [RN*PW-1:0] d;
        a = {LW'(2*j + 1), LW'(2*j)};
        d = {PW'(2*j + 11), PW'(2*j + 10)};
        check("rec_busy", 32'(busy), 32'd1);
        check("rec_stalls", {30'd0, rename_stall, commit_stall}, 32'd3);
        check("rec_ret_wr_en", 32'(ret_wr_en), 32'd0);
        check("rec_ret_rd_addr", 32'(ret_rd_addr), 32'(a));
        check("rec_ren_wr_en", 32'(ren_wr_en), 32'd3);
        check("rec_ren_wr_addr", 32'(ren_wr_addr), 32'(a));
        check("rec_ren_wr_data", 32'(ren_wr_data), 32'(d));
        check("rec_done", 32'(done), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_stalls"}, {30'd0, rename_stall, commit_stall}, 32'd0);
        check({tag, "_ret_wr"}, {18'd0, ret_wr_en, ret_wr_addr, ret_wr_data}, 32'd0);
        check({tag, "_ret_rd_addr"}, 32'(ret_rd_addr), 32'd0);
        check({tag, "_ren_wr_en"}, 32'(ren_wr_en), 32'd0);
        check({tag, "_ren_wr_addr"}, 32'(ren_wr_addr), 32'd0);
        check({tag, "_ren_wr_data"}, 32'(ren_wr_data), 32'd0);
    endtask

    initial begin
        for (int r = 0; r < 64; r++) rmap[r] = PW'(r + 10);
        rst_n       = 1'b0;
        init_start  = 1'b0;
        recover_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
`ifdef RMT_AUTO_INIT_EN
        step();
        chk_init(0);
        repeat (64) step();
        check("auto_done", 32'(done), 32'd1);
`endif
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Init sweep.
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk_init(i);
            step();
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);

        // Recovery copy, single-cycle request.
        recover_req = 1'b1;
        step();
        recover_req = 1'b0;
        for (int j = 0; j < 32; j++) begin
            chk_recover(j);
            step();
        end
        check("t2_done", 32'(done), 32'd1);
        check("t2_busy_end", 32'(busy), 32'd0);
        check("t2_ren_wr_en_end", 32'(ren_wr_en), 32'd0);
        step();
        check("t2_done_pulse", 32'(done), 32'd0);

        // Simultaneous requests: init wins, recovery dropped.
        init_start  = 1'b1;
        recover_req = 1'b1;
        step();
        init_start  = 1'b0;
        recover_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk_init(i);
            step();
        end
        check("t3_done", 32'(done), 32'd1);
        step();
        check("t3_no_recover", 32'(busy), 32'd0);
        step();
        check("t3_still_idle", 32'(busy), 32'd0);

        // Init aborts recovery at cycle 5.
        recover_req = 1'b1;
        step();
        recover_req = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk_recover(j);
            step();
        end
        init_start = 1'b1;
        chk_recover(5);
        step();
        init_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk_init(i);
            step();
        end
        check("t4_done", 32'(done), 32'd1);
        step();
        check("t4_done_pulse", 32'(done), 32'd0);

        // recover_req held high through the whole copy.
        recover_req = 1'b1;
        step();
        for (int j = 0; j < 32; j++) begin
            chk_recover(j);
            step();
        end
        check("t6_done", 32'(done), 32'd1);
        check("t6_busy_end", 32'(busy), 32'd0);
        step();
        check("t6_resample_busy", 32'(busy), 32'd1);
        check("t6_resample_addr", 32'(ren_wr_addr), {20'd0, 6'd1, 6'd0});
        recover_req = 1'b0;
        repeat (32) step();
        check("t6_done2", 32'(done), 32'd1);
        step();

        // Asynchronous reset mid-init.
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        repeat (20) step();
        chk_init(20);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        step();
        rst_n = 1'b1;
        step();
`ifdef RMT_AUTO_INIT_EN
        check("t5_auto_busy", 32'(busy), 32'd1);
        check("t5_auto_addr", 32'(ret_wr_addr), 32'd0);
`else
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_no_done", 32'(done), 32'd0);
`endif
        step();
        check("t5_no_done2", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
